// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings, FSM states
// and datapath width.
package alu_pkg;

    localparam int WORD_W = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } seq_state_t;

    function automatic logic isDefinedOp(input logic [3:0] op);
        case (op)
            OP_AND, OP_XOR, OP_SUB, OP_ADD,
            OP_CMP, OP_ORR, OP_MUL: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer in front of the 32-bit ALU: single-cycle ops, shift-add MUL, flag register.
// Optional macro ALU_SEQ_ILLEGAL_TRAP_EN traps undefined opcodes with res_illegal.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [WORD_W-1:0] cmd_a,
    input  logic [WORD_W-1:0] cmd_b,
    input  logic [3:0]        cmd_rd,
    input  logic              cmd_s,
    output logic [3:0]        alu_op,
    output logic [WORD_W-1:0] alu_op1,
    output logic [WORD_W-1:0] alu_op2,
    input  logic [WORD_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_lt,
    input  logic              alu_gt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic [3:0]        res_rd,
    output logic              res_wb,
    output logic              flag_z,
    output logic              flag_lt,
    output logic              flag_gt
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic              res_illegal
`endif
);

    localparam logic [5:0] ITERS_LAST = 6'(MUL_ITERS - 1);

    seq_state_t        r_state;
    seq_state_t        w_stateNext;
    seq_state_t        w_entryState;
    logic              w_accept;
    logic              w_mulLast;

    logic [3:0]        r_op;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic [3:0]        r_rd;
    logic              r_s;
    logic [WORD_W-1:0] r_acc;
    logic [5:0]        r_cnt;

    logic [WORD_W-1:0] r_resData;
    logic [3:0]        r_resRd;
    logic              r_resWb;
    logic              r_flagZ;
    logic              r_flagLt;
    logic              r_flagGt;

    assign w_accept  = cmd_valid && cmd_ready;
    assign w_mulLast = (r_b[WORD_W-1:1] == '0) || (r_cnt == ITERS_LAST);

    // Where a freshly accepted command goes; trapped opcodes skip execution entirely
    always_comb begin
        w_entryState = EXEC;
        if (cmd_op == OP_MUL) begin
            w_entryState = MUL;
        end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (!isDefinedOp(cmd_op)) begin
            w_entryState = DONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        cmd_ready   = 1'b0;
        alu_op      = OP_AND;
        alu_op1     = '0;
        alu_op2     = '0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_stateNext = w_entryState;
                end
            end
            EXEC: begin
                alu_op      = r_op;
                alu_op1     = r_a;
                alu_op2     = r_b;
                w_stateNext = DONE;
            end
            MUL: begin
                alu_op  = OP_ADD;
                alu_op1 = r_acc;
                alu_op2 = r_b[0] ? r_a : '0;
                if (w_mulLast) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                cmd_ready = res_ready;
                if (res_ready) begin
                    w_stateNext = cmd_valid ? w_entryState : IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic r_resIllegal;
    assign res_illegal = r_resIllegal;
`endif

    // Command latch, shift-add datapath (r_a = multiplicand, r_b = multiplier), result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_AND;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_s       <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_resData <= '0;
            r_resRd   <= '0;
            r_resWb   <= 1'b0;
            r_flagZ   <= 1'b0;
            r_flagLt  <= 1'b0;
            r_flagGt  <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            r_resIllegal <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_a   <= cmd_a;
                r_b   <= cmd_b;
                r_rd  <= cmd_rd;
                r_s   <= cmd_s;
                r_acc <= '0;
                r_cnt <= '0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                if (!isDefinedOp(cmd_op)) begin
                    r_resData    <= '0;
                    r_resRd      <= cmd_rd;
                    r_resWb      <= 1'b0;
                    r_resIllegal <= 1'b1;
                end
`endif
            end
            case (r_state)
                EXEC: begin
                    r_resData <= alu_result;
                    r_resRd   <= r_rd;
                    r_resWb   <= (r_op != OP_CMP);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    r_resIllegal <= 1'b0;
`endif
                    if ((r_op == OP_CMP) || r_s) begin
                        r_flagZ  <= alu_zero;
                        r_flagLt <= alu_lt;
                        r_flagGt <= alu_gt;
                    end
                end
                MUL: begin
                    r_acc <= alu_result;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_mulLast) begin
                        r_resData <= alu_result;
                        r_resRd   <= r_rd;
                        r_resWb   <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                        r_resIllegal <= 1'b0;
`endif
                        if (r_s) begin
                            r_flagZ  <= (alu_result == '0);
                            r_flagLt <= 1'b0;
                            r_flagGt <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (r_state == DONE);
    assign res_data  = r_resData;
    assign res_rd    = r_resRd;
    assign res_wb    = r_resWb;
    assign flag_z    = r_flagZ;
    assign flag_lt   = r_flagLt;
    assign flag_gt   = r_flagGt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU stub, directed steps, then random commands
// compared against a plain-arithmetic reference model.
module tb_alu_sequencer;

    localparam int MUL_ITERS = 32;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_rd;
    logic        cmd_s;
    logic [3:0]  alu_op;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_gt;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_rd;
    logic        res_wb;
    logic        flag_z;
    logic        flag_lt;
    logic        flag_gt;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        res_illegal;
`endif

    alu_sequencer #(.MUL_ITERS(MUL_ITERS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_rd     (cmd_rd),
        .cmd_s      (cmd_s),
        .alu_op     (alu_op),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_gt     (alu_gt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_wb     (res_wb),
        .flag_z     (flag_z),
        .flag_lt    (flag_lt),
        .flag_gt    (flag_gt)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        ,
        .res_illegal(res_illegal)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the external ALU
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_op1 & alu_op2;
            4'b0001: alu_result = alu_op1 ^ alu_op2;
            4'b0010: alu_result = alu_op1 - alu_op2;
            4'b0100: alu_result = alu_op1 + alu_op2;
            4'b1010: alu_result = alu_op1 - alu_op2;
            4'b1100: alu_result = alu_op1 | alu_op2;
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
        alu_lt   = (alu_op1 < alu_op2);
        alu_gt   = (alu_op1 > alu_op2);
    end

    int nChecks = 0;
    int nPass   = 0;

    logic [31:0] expData;
    logic        expWb;
    logic [3:0]  expRd;
    logic        expIll;
    int          expLat;
    logic        mZ = 1'b0;
    logic        mLt = 1'b0;
    logic        mGt = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic isLegal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1001};
    endfunction

    // Number of shift-add steps: position of the multiplier's top set bit, capped
    function automatic int mulSteps(input logic [31:0] b);
        for (int i = 31; i >= 0; i--) begin
            if (b[i]) return ((i + 1) > MUL_ITERS) ? MUL_ITERS : (i + 1);
        end
        return 1;
    endfunction

    // Drive one command (caller is at a negedge), predict its outcome, and accept it on the next edge
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] rd, input logic s);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_rd    = rd;
        cmd_s     = s;
        #1;
        checkOutput("cmd_ready.accept", cmd_ready, 1);
        expRd  = rd;
        expIll = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (!isLegal(op)) begin
            expData = 32'h0;
            expWb   = 1'b0;
            expIll  = 1'b1;
            expLat  = 1;
        end else
`endif
        begin
            case (op)
                4'b0000: expData = a & b;
                4'b0001: expData = a ^ b;
                4'b0010: expData = a - b;
                4'b0100: expData = a + b;
                4'b1010: expData = a - b;
                4'b1100: expData = a | b;
                4'b1001: expData = a * b;
                default: expData = 32'h0;
            endcase
            expWb  = (op != 4'b1010);
            expLat = (op == 4'b1001) ? 1 + mulSteps(b) : 2;
            if (op == 4'b1010 || s) begin
                mZ  = (expData == 32'h0);
                mLt = (op == 4'b1001) ? 1'b0 : (a < b);
                mGt = (op == 4'b1001) ? 1'b0 : (a > b);
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int lat = 1;
        @(negedge clk);
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".res_data"}, res_data, expData);
        checkOutput({tag, ".res_wb"}, res_wb, expWb);
        checkOutput({tag, ".res_rd"}, res_rd, expRd);
        checkOutput({tag, ".flags"}, {flag_z, flag_lt, flag_gt}, {mZ, mLt, mGt});
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        checkOutput({tag, ".res_illegal"}, res_illegal, expIll);
`endif
    endtask

    task automatic releaseResult(input string tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".released"}, res_valid, 0);
    endtask

    logic [3:0] randOps [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1001, 4'b0111};

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 32'h0;
        cmd_b     = 32'h0;
        cmd_rd    = 4'h0;
        cmd_s     = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        checkOutput("reset.res_valid", res_valid, 0);
        checkOutput("reset.res_data", res_data, 0);
        checkOutput("reset.res_rd", res_rd, 0);
        checkOutput("reset.res_wb", res_wb, 0);
        checkOutput("reset.flags", {flag_z, flag_lt, flag_gt}, 0);
        checkOutput("reset.alu", {alu_op, alu_op1[27:0]} | {4'h0, alu_op2[27:0]}, 0);
        checkOutput("reset.cmd_ready", cmd_ready, 1);

        applyStimulus(4'b0100, 32'd7, 32'd5, 4'd3, 1'b0);
        checkOutput("add.alu_op", alu_op, 4'b0100);
        checkOutput("add.alu_op1", alu_op1, 7);
        checkOutput("add.alu_op2", alu_op2, 5);
        waitResult("add");
        checkOutput("add.value", res_data, 12);
        releaseResult("add");

        applyStimulus(4'b1010, 32'd3, 32'd9, 4'd1, 1'b0);
        waitResult("cmp");
        checkOutput("cmp.lt", {flag_z, flag_lt, flag_gt}, 3'b010);
        releaseResult("cmp");

        applyStimulus(4'b0010, 32'd9, 32'd9, 4'd2, 1'b1);
        waitResult("sub");
        checkOutput("sub.z", flag_z, 1);
        releaseResult("sub");

        applyStimulus(4'b1001, 32'h1234, 32'd5, 4'd4, 1'b0);
        waitResult("mul5");
        checkOutput("mul5.value", res_data, 32'h5B04);
        releaseResult("mul5");

        applyStimulus(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b1);
        waitResult("mulmax");
        checkOutput("mulmax.lat", expLat, 33);
        releaseResult("mulmax");

        // Result held in DONE while a queued command waits, then taken back-to-back
        applyStimulus(4'b0100, 32'd100, 32'd23, 4'd7, 1'b0);
        waitResult("hold");
        cmd_valid = 1'b1;
        cmd_op    = 4'b0001;
        cmd_a     = 32'hF0F0_1234;
        cmd_b     = 32'h0FF0_4321;
        cmd_rd    = 4'd9;
        repeat (4) begin
            #1;
            checkOutput("hold.cmd_ready", cmd_ready, 0);
            checkOutput("hold.res_valid", res_valid, 1);
            checkOutput("hold.res_data", res_data, 123);
            checkOutput("hold.res_rd", res_rd, 7);
            @(negedge clk);
        end
        res_ready = 1'b1;
        applyStimulus(4'b0001, 32'hF0F0_1234, 32'h0FF0_4321, 4'd9, 1'b0);
        checkOutput("b2b.exec_op", alu_op, 4'b0001);
        checkOutput("b2b.res_valid", res_valid, 0);
        waitResult("b2b");
        releaseResult("b2b");

        applyStimulus(4'b1010, 32'd9, 32'd3, 4'd0, 1'b0);
        waitResult("cmpgt");
        releaseResult("cmpgt");

        // Reset during the second MUL step must discard the command
        applyStimulus(4'b1001, 32'd1, 32'hFFFF_FFFF, 4'd6, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mZ = 1'b0; mLt = 1'b0; mGt = 1'b0;
        checkOutput("rstmul.res_valid", res_valid, 0);
        checkOutput("rstmul.flags", {flag_z, flag_lt, flag_gt}, 0);
        checkOutput("rstmul.cmd_ready", cmd_ready, 1);
        checkOutput("rstmul.res_data", res_data, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstmul.no_result", res_valid, 0);
        end

        applyStimulus(4'b0111, 32'd5, 32'd9, 4'd8, 1'b1);
        waitResult("undef");
        releaseResult("undef");

        for (int i = 0; i < 25; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = randOps[$urandom_range(0, 7)];
            if (op == 4'b0111) op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (op == 4'b1001 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) b = a;
            applyStimulus(op, a, b, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            waitResult(isLegal(op) ? "rand" : "rand_undef");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            releaseResult("rand");
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
